// File: rtl/bambu_extmem_model.sv
// Off-chip memory model for HLS master ports: N channels, byte-array storage,
// independent read/write latency, size-masked writes and sticky error flags.
module bambu_extmem_model #(
  parameter int CHANNELS  = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int BASE_ADDR = 0,
  parameter int MEM_BYTES = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic                         ld_en,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [7:0]                   ld_data,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  output logic [CHANNELS-1:0]          err_conflict,
  output logic                         err_range
);

  localparam int IW   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] RL1 = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WL1 = CW'(WRITE_LAT - 1);

  logic [DATA_W-1:0] mem [MEM_BYTES];

  logic [ADDR_W-1:0] addr    [CHANNELS];
  logic [DATA_W-1:0] wdata   [CHANNELS];
  logic [SIZE_W-1:0] size    [CHANNELS];
  logic [DATA_W-1:0] mask    [CHANNELS];
  logic [DATA_W-1:0] rd_byte [CHANNELS];
  logic [DATA_W-1:0] merged  [CHANNELS];
  logic [DATA_W-1:0] rd_out  [CHANNELS];
  logic [CW-1:0]     cnt     [CHANNELS];
  logic [CW-1:0]     cnt_nxt [CHANNELS];

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] rd_req;
  logic [CHANNELS-1:0] wr_req;
  logic [CHANNELS-1:0] conflict;
  logic [CHANNELS-1:0] done;

  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    int x;
    x = int'(a);
    return (x >= BASE_ADDR) && (x < BASE_ADDR + MEM_BYTES);
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_W-1:0] a);
    return IW'(int'(a) - BASE_ADDR);
  endfunction

  always_comb begin
    hit      = '0;
    rd_req   = '0;
    wr_req   = '0;
    conflict = '0;
    done     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      addr[c]    = Mout_addr_ram[c*ADDR_W +: ADDR_W];
      wdata[c]   = Mout_Wdata_ram[c*DATA_W +: DATA_W];
      size[c]    = Mout_data_ram_size[c*SIZE_W +: SIZE_W];
      hit[c]     = in_win(addr[c]);
      conflict[c] = Mout_oe_ram[c] & Mout_we_ram[c];
      rd_req[c]  = Mout_oe_ram[c] & ~Mout_we_ram[c] & hit[c];
      wr_req[c]  = Mout_we_ram[c] & ~Mout_oe_ram[c] & hit[c];
      rd_byte[c] = hit[c] ? mem[idx(addr[c])] : '0;
      // Mask keeps the low `size` bits of wdata; saturates at full width
      for (int b = 0; b < DATA_W; b++) begin
        mask[c][b] = int'(size[c]) > b;
      end
      merged[c] = (wdata[c] & mask[c]) | (rd_byte[c] & ~mask[c]);
      cnt_nxt[c] = '0;
      if (rd_req[c]) begin
        done[c] = (cnt[c] == RL1);
        cnt_nxt[c] = done[c] ? '0 : cnt[c] + 1'b1;
      end else if (wr_req[c]) begin
        done[c] = (cnt[c] == WL1);
        cnt_nxt[c] = done[c] ? '0 : cnt[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= cnt_nxt[c];
      end
    end
  end

  // Read data is sampled every cycle; after READ_LAT-1 stages the
  // value seen at the ready cycle is the one from the first request cycle.
  if (READ_LAT > 1) begin : g_pipe
    logic [DATA_W-1:0] pipe [CHANNELS][READ_LAT-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int c = 0; c < CHANNELS; c++) begin
          for (int k = 0; k < READ_LAT - 1; k++) begin
            pipe[c][k] <= '0;
          end
        end
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          pipe[c][0] <= rd_byte[c];
          for (int k = 1; k < READ_LAT - 1; k++) begin
            pipe[c][k] <= pipe[c][k-1];
          end
        end
      end
    end

    always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_out[c] = pipe[c][READ_LAT-2];
      end
    end
  end else begin : g_comb
    always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_out[c] = rd_byte[c];
      end
    end
  end

  // Later assignments win: higher channels over lower, preload over all
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_req[c] && (cnt[c] == '0)) begin
        mem[idx(addr[c])] <= merged[c];
      end
    end
    if (ld_en && in_win(ld_addr)) begin
      mem[idx(ld_addr)] <= DATA_W'(ld_data);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_conflict <= '0;
      err_range    <= 1'b0;
    end else begin
      err_conflict <= err_conflict | conflict;
      err_range    <= err_range | (ld_en & ~in_win(ld_addr));
    end
  end

  always_comb begin
    M_DataRdy   = '0;
    M_Rdata_ram = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      M_DataRdy[c] = done[c];
      if (done[c] && rd_req[c]) begin
        M_Rdata_ram[c*DATA_W +: DATA_W] = rd_out[c];
      end
    end
  end

endmodule

// File: tb/tb_bambu_extmem_model.sv
// Directed plus randomized checks of bambu_extmem_model against a byte-array
// model with latency, window, mask and arbitration rules applied directly.
module tb_bambu_extmem_model;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [15:0] wdata;
  logic [7:0]  size;
  logic        ld_en;
  logic [6:0]  ld_addr;
  logic [7:0]  ld_data;

  logic [15:0] rdata, rdata3;
  logic [1:0]  rdy, rdy3, ec, ec3;
  logic        er, er3;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [32];

  always #5 clock = ~clock;

  bambu_extmem_model dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
    .Mout_data_ram_size(size),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy),
    .err_conflict(ec), .err_range(er)
  );

  bambu_extmem_model #(.READ_LAT(3), .WRITE_LAT(2)) dut3 (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we),
    .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
    .Mout_data_ram_size(size),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .M_Rdata_ram(rdata3), .M_DataRdy(rdy3),
    .err_conflict(ec3), .err_range(er3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] merge(input logic [7:0] old,
                                       input logic [7:0] d,
                                       input int s);
    logic [7:0] mk;
    mk = (s >= 8) ? 8'hFF : 8'((9'd1 << s) - 9'd1);
    return (d & mk) | (old & ~mk);
  endfunction

  task automatic clear_all();
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic set_ch(input int c, input bit r, input bit w,
                        input logic [6:0] a, input logic [7:0] d,
                        input logic [3:0] s);
    oe[c] = r;
    we[c] = w;
    addr[c*7 +: 7] = a;
    wdata[c*8 +: 8] = d;
    size[c*4 +: 4] = s;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    @(negedge clock);
    clear_all();
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    if (a < 7'd32) m[a[4:0]] = d;
  endtask

  // One request held for its latency (or 5 cycles if out of window)
  task automatic access(input int c, input bit w, input logic [6:0] a,
                        input logic [7:0] d, input logic [3:0] s);
    int lat, last;
    bit inw;
    logic [7:0] exp_rd;
    inw = (a < 7'd32);
    lat = w ? 1 : 2;
    last = inw ? lat : 5;
    exp_rd = inw ? m[a[4:0]] : 8'h00;
    @(negedge clock);
    clear_all();
    set_ch(c, !w, w, a, d, s);
    for (int k = 1; k <= last; k++) begin
      #1;
      chk("rdy", rdy[c], inw && k == lat);
      chk("rdata", rdata[c*8 +: 8],
          (inw && !w && k == lat) ? exp_rd : 8'h00);
      chk("other_rdy", rdy[1-c], 1'b0);
      if (k < last) @(negedge clock);
    end
    if (w && inw) m[a[4:0]] = merge(m[a[4:0]], d, int'(s));
    @(negedge clock);
    clear_all();
  endtask

  initial begin
    logic [7:0] old9, old14;
    clear_all();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_rdy", rdy, 2'b00);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_ec", ec, 2'b00);
    chk("rst_er", er, 1'b0);
    chk("rst_rdy3", rdy3, 2'b00);
    chk("rst_rdata3", rdata3, 16'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) preload(7'(i), 8'($urandom));
    preload(7'd3, 8'hA5);
    preload(7'd5, 8'h30);
    @(negedge clock);
    clear_all();

    access(0, 0, 7'd3, 8'h00, 4'd8);
    access(1, 1, 7'd5, 8'hFF, 4'd4);
    access(0, 0, 7'd5, 8'h00, 4'd8);
    chk("mask_model", m[5], 8'h3F);

    @(negedge clock);
    clear_all();
    set_ch(0, 0, 1, 7'd7, 8'h11, 4'd8);
    set_ch(1, 0, 1, 7'd7, 8'h22, 4'd8);
    #1;
    chk("dual_rdy", rdy, 2'b11);
    m[7] = 8'h22;
    @(negedge clock);
    clear_all();
    access(1, 0, 7'd7, 8'h00, 4'd8);

    access(0, 0, 7'd40, 8'h00, 4'd8);

    old9 = m[9];
    @(negedge clock);
    clear_all();
    set_ch(0, 1, 1, 7'd9, ~old9, 4'd8);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("conf_rdy", rdy[0], 1'b0);
      if (k > 1) chk("conf_flag", ec, 2'b01);
      @(negedge clock);
    end
    clear_all();
    access(0, 0, 7'd9, 8'h00, 4'd8);
    chk("conf_sticky", ec, 2'b01);

    #1;
    chk("range_pre", er, 1'b0);
    preload(7'd100, 8'h00);
    @(negedge clock);
    clear_all();
    #1;
    chk("range_set", er, 1'b1);

    @(negedge clock);
    clear_all();
    ld_en = 1'b1; ld_addr = 7'd12; ld_data = 8'h5A;
    set_ch(1, 0, 1, 7'd12, 8'hC3, 4'd8);
    #1;
    chk("ld_win_rdy", rdy[1], 1'b1);
    m[12] = 8'h5A;
    @(negedge clock);
    clear_all();
    access(0, 0, 7'd12, 8'h00, 4'd8);

    old14 = m[14];
    @(negedge clock);
    clear_all();
    set_ch(0, 1, 0, 7'd14, 8'h00, 4'd8);
    set_ch(1, 0, 1, 7'd14, ~old14, 4'd8);
    #1;
    chk("rw_wrdy", rdy, 2'b10);
    @(negedge clock);
    set_ch(1, 0, 0, 7'd0, 8'h00, 4'd0);
    #1;
    chk("rw_rrdy", rdy[0], 1'b1);
    chk("rw_old", rdata[7:0], old14);
    m[14] = ~old14;
    @(negedge clock);
    clear_all();
    access(1, 0, 7'd14, 8'h00, 4'd8);

    for (int i = 0; i < 60; i++) begin
      access(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             7'($urandom_range(39, 0)), 8'($urandom),
             4'($urandom_range(9, 0)));
    end
    access(0, 1, 7'd20, 8'hFF, 4'd0);
    access(0, 0, 7'd20, 8'h00, 4'd8);

    @(negedge clock);
    clear_all();
    reset = 1'b1;
    set_ch(0, 1, 0, 7'd3, 8'h00, 4'd8);
    #1;
    chk("rst3_c1", rdy3[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("rst3_rdy", rdy3[0], k == 3);
      chk("rst3_rdata", rdata3[7:0], (k == 3) ? m[3] : 8'h00);
      @(negedge clock);
    end
    clear_all();
    #1;
    chk("rst_ec_clr", ec, 2'b00);
    chk("rst_er_clr", er, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
